// File: rtl/ne555_pulse_meter_pkg.sv
// Shared types and constants for the NE555 pulse meter and its prescaler.
package ne555_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned RATE_W        = 4;
    localparam int unsigned PRESCALE_W    = (1 << RATE_W) - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        STALL = 3'd4
    } meter_state_t;

endpackage

// File: rtl/ne555_pulse_meter_if.sv
// Result port of the pulse meter: one measurement per valid/ready transfer.
interface ne555_pulse_meter_if
    import ne555_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] high_ticks;
    logic [CNT_W-1:0] low_ticks;
    logic [CNT_W:0]   period_ticks;

    modport master (
        output meas_valid,
        output high_ticks,
        output low_ticks,
        output period_ticks,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  high_ticks,
        input  low_ticks,
        input  period_ticks,
        output meas_ready
    );

endinterface

// File: rtl/ne555_tick_gen.sv
// Free-running prescaler: tick is high one cycle in every 2^rate cycles.
module ne555_tick_gen
    import ne555_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    localparam logic [PRESCALE_W-1:0] ALL_ONES = '1;

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic [PRESCALE_W-1:0] mask;

    always_comb begin
        mask  = ~(ALL_ONES << rate);
        pre_d = clr ? '0 : pre_q + PRESCALE_W'(1);
    end

    // Tick when the low 'rate' bits roll over; rate=0 gives an all-zero mask.
    assign tick = ((pre_q & mask) == mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/ne555_pulse_meter.sv
// Measures high/low/period of an asynchronous waveform in prescaled ticks and
// publishes each completed cycle on a valid/ready result port.
module ne555_pulse_meter
    import ne555_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [RATE_W-1:0]      rate,
    input  logic                   sig_in,
    ne555_pulse_meter_if.master    meas,
    output logic                   overrun,
    output logic                   timeout,
    output logic                   level,
    output logic [2:0]             state_dbg
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   tick;

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   per_q, per_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;
    logic             publish;
    logic             cnt_sat;

    // Synchronizer and edge detect keep running while disabled so level tracks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~s_d_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & s_d_q;
        end
    end

    ne555_tick_gen u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~enable | clear),
        .rate  (rate),
        .tick  (tick)
    );

    assign cnt_sat = &cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        high_d  = high_q;
        low_d   = low_q;
        per_d   = per_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        to_d    = to_q;
        publish = 1'b0;

        if (!enable || clear) begin
            state_d = enable ? ARM : IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            high_d  = '0;
            low_d   = '0;
            per_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            to_d    = 1'b0;
        end else begin
            if (rise_q || fall_q) begin
                cnt_d = CNT_W'(tick);
            end else if (!cnt_sat) begin
                cnt_d = cnt_q + CNT_W'(tick);
            end

            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise_q) state_d = HIGH;
                end
                HIGH: begin
                    if (fall_q) begin
                        hold_d  = cnt_q;
                        state_d = LOW;
                    end else if (tick && cnt_sat) begin
                        state_d = STALL;
                        to_d    = 1'b1;
                    end
                end
                LOW: begin
                    if (rise_q) begin
                        publish = 1'b1;
                        state_d = HIGH;
                    end else if (tick && cnt_sat) begin
                        state_d = STALL;
                        to_d    = 1'b1;
                    end
                end
                STALL: begin
                    if (rise_q) state_d = HIGH;
                end
                default: state_d = ARM;
            endcase

            // An unconsumed result is never overwritten unless it is taken this cycle.
            if (publish) begin
                if (!valid_q || meas.meas_ready) begin
                    high_d  = hold_q;
                    low_d   = cnt_q;
                    per_d   = {1'b0, hold_q} + {1'b0, cnt_q};
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (valid_q && meas.meas_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            high_q  <= '0;
            low_q   <= '0;
            per_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            high_q  <= high_d;
            low_q   <= low_d;
            per_q   <= per_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign meas.meas_valid   = valid_q;
    assign meas.high_ticks   = high_q;
    assign meas.low_ticks    = low_q;
    assign meas.period_ticks = per_q;
    assign overrun           = ovr_q;
    assign timeout           = to_q;
    assign level             = sync_q[SYNC_STAGES-1];
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_ne555_pulse_meter.sv
// Bench for ne555_pulse_meter: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ne555_pulse_meter;
    import ne555_pkg::*;

    localparam int CW   = 8;
    localparam int SYNC = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [RATE_W-1:0] rate = '0;
    logic              sig_in = 1'b0;
    logic              ready = 1'b0;
    logic              overrun, timeout, level;
    logic [2:0]        state_dbg;

    ne555_pulse_meter_if #(.CNT_W(CW)) mif ();
    assign mif.meas_ready = ready;

    ne555_pulse_meter #(.CNT_W(CW), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .rate      (rate),
        .sig_in    (sig_in),
        .meas      (mif.master),
        .overrun   (overrun),
        .timeout   (timeout),
        .level     (level),
        .state_dbg (state_dbg)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d..%0d", nm, $time, act, lo, hi);
        end
    endtask

    // A window of n clk cycles holds floor or ceil of n/2^r prescaler ticks.
    task automatic cmp_ticks(input string nm, input int act, input int n, input int r);
        int p;
        p = 1 << r;
        cmp_rng(nm, act, n / p, (n + p - 1) / p);
    endtask

    // ---------------- reference model ----------------
    // Each sampled transition takes effect SYNC+1 edges after the edge that
    // first samples it; measurements are differences of those effect times.
    typedef struct {int due; bit rise;} ev_t;
    typedef enum int {WAIT_RISE, IN_HIGH, IN_LOW} ph_t;

    ev_t q[$];
    int  cyc = 0;
    bit  samp_prev = 0;
    bit  hist[SYNC];
    bit  idle = 1;
    ph_t phase = WAIT_RISE;
    int  e_start = 0;
    int  hold_c = 0;
    int  m_valid = 0, m_overrun = 0, m_timeout = 0, m_level = 0;
    int  m_hi = 0, m_lo = 0, m_rate = 0;

    task automatic model_zero();
        m_valid = 0; m_overrun = 0; m_timeout = 0;
        m_hi = 0; m_lo = 0; m_rate = 0;
        phase = WAIT_RISE;
    endtask

    task automatic model_step();
        ev_t ev;
        bit  have_ev, pub;
        int  ph, pl;
        cyc++;
        if (!rst_n) begin
            q.delete();
            samp_prev = 0;
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
            m_level = 0;
            idle = 1;
            model_zero();
            return;
        end
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
        m_level = hist[SYNC-1];
        if (sig_in != samp_prev) q.push_back('{cyc + SYNC + 1, sig_in});
        samp_prev = sig_in;

        have_ev = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = q.pop_front();
            have_ev = 1;
        end

        if (!enable) begin
            model_zero();
            idle = 1;
        end else if (idle) begin
            idle = 0;
            phase = WAIT_RISE;
        end else if (clear) begin
            model_zero();
        end else begin
            pub = 0; ph = 0; pl = 0;
            if (have_ev) begin
                if (ev.rise) begin
                    if (phase == IN_LOW) begin
                        pub = 1; ph = hold_c; pl = cyc - e_start;
                    end
                    phase = IN_HIGH;
                    e_start = cyc;
                end else if (phase == IN_HIGH) begin
                    hold_c = cyc - e_start;
                    phase = IN_LOW;
                    e_start = cyc;
                end
            end else if (phase != WAIT_RISE && rate == 0 && cyc - e_start == MAXC) begin
                phase = WAIT_RISE;
                m_timeout = 1;
            end
            if (pub) begin
                if (!m_valid || ready) begin
                    m_hi = ph; m_lo = pl; m_rate = int'(rate); m_valid = 1;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        cmp("valid", int'(mif.meas_valid), m_valid);
        cmp("overrun", int'(overrun), m_overrun);
        cmp("timeout", int'(timeout), m_timeout);
        cmp("level", int'(level), m_level);
        cmp_ticks("high", int'(mif.high_ticks), m_hi, m_rate);
        cmp_ticks("low", int'(mif.low_ticks), m_lo, m_rate);
        cmp_ticks("period", int'(mif.period_ticks), m_hi + m_lo, m_rate);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic seg(input bit v, input int n);
        sig_in = v;
        step(n);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        int p;
        bit found;
        int dur;
        int rdy_pct;

        step(3);
        cmp("rst_valid", int'(mif.meas_valid), 0);
        cmp("rst_high", int'(mif.high_ticks), 0);
        cmp("rst_low", int'(mif.low_ticks), 0);
        cmp("rst_period", int'(mif.period_ticks), 0);
        cmp("rst_overrun", int'(overrun), 0);
        cmp("rst_timeout", int'(timeout), 0);
        cmp("rst_level", int'(level), 0);
        cmp("rst_state", int'(state_dbg), 0);
        rst_n = 1'b1;
        enable = 1'b1;

        // 7 high / 5 low at rate 0, with result latency
        seg(0, 5);
        seg(1, 7);
        seg(0, 5);
        sig_in = 1'b1;
        p = cyc;
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1);
            if (mif.meas_valid) found = 1;
        end
        cmp("t1_latency", found ? cyc - p : -1, 4);
        cmp("t1_high", int'(mif.high_ticks), 7);
        cmp("t1_low", int'(mif.low_ticks), 5);
        cmp("t1_period", int'(mif.period_ticks), 12);

        // unconsumed result is retained, second one flagged as overrun
        step(5);
        seg(0, 3);
        seg(1, 5);
        cmp("ovr_flag", int'(overrun), 1);
        cmp("ovr_keep_high", int'(mif.high_ticks), 7);
        cmp("ovr_keep_low", int'(mif.low_ticks), 5);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        cmp("ovr_consumed", int'(mif.meas_valid), 0);
        pulse_clear();
        cmp("ovr_cleared", int'(overrun), 0);

        // publish coinciding with ready while a result is held
        seg(0, 4);
        seg(1, 6);
        seg(0, 4);
        seg(1, 6);
        seg(0, 8);
        sig_in = 1'b1;
        step(3);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        cmp("coin_valid", int'(mif.meas_valid), 1);
        cmp("coin_high", int'(mif.high_ticks), 6);
        cmp("coin_low", int'(mif.low_ticks), 8);
        cmp("coin_period", int'(mif.period_ticks), 14);
        cmp("coin_overrun", int'(overrun), 0);

        // rate=2: 40/24 clk -> about 10/6 ticks
        rate = 4'd2;
        pulse_clear();
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seg(1, 40);
            seg(0, 24);
        end
        cmp_rng("r2_high", int'(mif.high_ticks), 9, 11);
        cmp_rng("r2_low", int'(mif.low_ticks), 5, 7);
        cmp("r2_period", int'(mif.period_ticks), 16);
        rate = 4'd0;
        pulse_clear();

        // level longer than 2^CW-1 ticks -> STALL and sticky timeout
        ready = 1'b0;
        seg(0, 5);
        seg(1, 300);
        cmp("stall_timeout", int'(timeout), 1);
        cmp("stall_novalid", int'(mif.meas_valid), 0);
        cmp("stall_state", int'(state_dbg), 4);
        seg(0, 5);
        seg(1, 7);
        seg(0, 5);
        seg(1, 6);
        cmp("post_stall_valid", int'(mif.meas_valid), 1);
        cmp("post_stall_high", int'(mif.high_ticks), 7);
        cmp("post_stall_low", int'(mif.low_ticks), 5);
        cmp("post_stall_timeout", int'(timeout), 1);

        // disable mid-HIGH, re-enable
        seg(0, 5);
        seg(1, 3);
        enable = 1'b0;
        step(3);
        cmp("dis_state", int'(state_dbg), 0);
        cmp("dis_valid", int'(mif.meas_valid), 0);
        cmp("dis_high", int'(mif.high_ticks), 0);
        cmp("dis_period", int'(mif.period_ticks), 0);
        cmp("dis_overrun", int'(overrun), 0);
        cmp("dis_timeout", int'(timeout), 0);
        cmp("dis_level", int'(level), 1);
        enable = 1'b1;
        step(1);
        cmp("reen_state", int'(state_dbg), 1);
        step(4);
        seg(0, 5);
        seg(1, 7);
        seg(0, 5);
        cmp("reen_noresult", int'(mif.meas_valid), 0);
        seg(1, 6);
        cmp("reen_valid", int'(mif.meas_valid), 1);
        cmp("reen_high", int'(mif.high_ticks), 7);
        cmp("reen_low", int'(mif.low_ticks), 5);

        // random traffic, including levels around the saturation boundary
        dur = 1;
        rdy_pct = 50;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            if (i % 500 == 0) rdy_pct = $urandom_range(0, 3) * 33 + 1;
            ready = ($urandom_range(0, 99) < rdy_pct);
            clear = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                rate = RATE_W'($urandom_range(0, 3));
                clear = 1'b1;
            end
            if (i % 1900 == 1899) enable = 1'b0;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            dur--;
            if (dur == 0) begin
                sig_in = ~sig_in;
                if ($urandom_range(0, 99) < 3) dur = $urandom_range(253, 258);
                else dur = $urandom_range(1, 30);
            end
        end
        clear = 1'b0;
        enable = 1'b1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
